// File: rtl/ahb_ral_ahb_regmem_if.sv
// AHB-Lite bus bundle between the bench master and the RAL register/memory slave.
// Clock and reset stay outside the interface as plain ports.
interface ahb_ral_ahb_regmem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_ral_ahb_regmem.sv
// AHB-Lite slave: word RAM window at 0x0 plus CTRL/STATUS/IRQ/MASK register bank,
// with programmable wait states, two-cycle ERROR response and a masked interrupt output.
module ahb_ral_ahb_regmem #(
  parameter int RAM_BYTES   = 4096,
  parameter int REG_BASE    = 'h1000,
  parameter int WAIT_STATES = 0,
  parameter int ERR_EN      = 1
) (
  input  logic                 i_hclk,
  input  logic                 i_hreset,
  ahb_ral_ahb_regmem_if.slave  bus,
  output logic [31:0]          o_ctrl,
  input  logic [31:0]          i_sta,
  input  logic [31:0]          i_evt,
  output logic                 o_irq
);

  localparam int          RAM_WORDS = RAM_BYTES / 4;
  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_LIM   = 32'(RAM_BYTES);
  localparam logic [31:0] REG_LO    = 32'(REG_BASE);
  localparam logic [31:0] REG_HI    = 32'(REG_BASE + 16);
  localparam logic [3:0]  WS_M1     = 4'(WAIT_STATES - 1);
  localparam logic [31:0] IDLE_DATA = 32'h0BAD_CAFE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_hreadyout;
  logic        r_hresp;
  logic        r_dp_valid;
  logic        r_bad;
  logic        r_write;
  logic        r_in_reg;
  logic [3:0]  r_cnt;
  logic [3:0]  r_be;
  logic [15:0] r_addr;

  logic [31:0] r_ctrl;
  logic [31:0] r_irq;
  logic [31:0] r_mask;
  logic [31:0] r_mem [RAM_WORDS];

  logic [15:0]       w_a16;
  logic [31:0]       w_a32;
  logic              w_in_ram;
  logic              w_in_reg;
  logic              w_misal;
  logic              w_err;
  logic              w_accept;
  logic [3:0]        w_be;
  logic              w_done;
  logic              w_wr_commit;
  logic              w_ram_we;
  logic              w_reg_we;
  logic [1:0]        w_reg_idx;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [31:0]       w_irq_clr;
  logic [31:0]       w_rdata;

  assign w_a16    = bus.haddr[15:0];
  assign w_a32    = {16'h0000, w_a16};
  assign w_in_ram = (w_a32 < RAM_LIM);
  assign w_in_reg = (w_a32 >= REG_LO) && (w_a32 < REG_HI);
  assign w_accept = bus.hsel & bus.htrans[1] & r_hreadyout;

  // Address-phase decode: alignment, size legality and lane enables.
  always_comb begin
    w_misal = 1'b0;
    w_be    = 4'b0000;
    case (bus.hsize)
      3'd0: w_be = 4'b0001 << w_a16[1:0];
      3'd1: begin
        w_misal = w_a16[0];
        w_be    = w_a16[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        w_misal = (w_a16[1:0] != 2'b00);
        w_be    = 4'b1111;
      end
      default: w_be = 4'b0000;
    endcase
    w_err = (!w_in_ram && !w_in_reg) || (bus.hsize > 3'd2) || w_misal ||
            (w_in_reg && (bus.hsize != 3'd2));
  end

  // An OKAY data phase completes in the cycle hreadyout returns high in IDLE.
  assign w_done      = r_dp_valid & r_hreadyout & (r_state == S_IDLE);
  assign w_wr_commit = w_done & r_write & ~r_bad & ~i_hreset;
  assign w_ram_we    = w_wr_commit & ~r_in_reg;
  assign w_reg_we    = w_wr_commit & r_in_reg;
  assign w_reg_idx   = r_addr[3:2];
  assign w_ram_idx   = r_addr[RAM_AW+1:2];
  assign w_irq_clr   = (w_reg_we && (w_reg_idx == 2'd2)) ? bus.hwdata : 32'h0000_0000;

  // Transfer FSM with registered hreadyout/hresp and captured data-phase controls.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_dp_valid  <= 1'b0;
      r_bad       <= 1'b0;
      r_write     <= 1'b0;
      r_in_reg    <= 1'b0;
      r_cnt       <= 4'd0;
      r_be        <= 4'b0000;
      r_addr      <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE, S_ERR2: begin
          if (w_accept) begin
            r_addr   <= w_a16;
            r_write  <= bus.hwrite;
            r_be     <= w_be;
            r_in_reg <= w_in_reg;
            if (w_err && (ERR_EN != 0)) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
              r_dp_valid  <= 1'b0;
              r_bad       <= 1'b1;
            end else begin
              r_hresp    <= 1'b0;
              r_dp_valid <= 1'b1;
              r_bad      <= w_err;
              if (WAIT_STATES > 0) begin
                r_state     <= S_WAIT;
                r_hreadyout <= 1'b0;
                r_cnt       <= WS_M1;
              end else begin
                r_state     <= S_IDLE;
                r_hreadyout <= 1'b1;
              end
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_dp_valid  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
          r_dp_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Register bank; an event on the same bit outranks a write-1-to-clear.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_ctrl <= 32'h0000_0000;
      r_irq  <= 32'h0000_0000;
      r_mask <= 32'h0000_0000;
    end else begin
      if (w_reg_we && (w_reg_idx == 2'd0)) begin
        r_ctrl <= bus.hwdata;
      end
      if (w_reg_we && (w_reg_idx == 2'd3)) begin
        r_mask <= bus.hwdata;
      end
      r_irq <= (r_irq & ~w_irq_clr) | i_evt;
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge i_hclk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[w_ram_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
        end
      end
    end
  end

  // Read-data mux, live only in the completing cycle of an OKAY read.
  always_comb begin
    w_rdata = IDLE_DATA;
    if (w_done && !r_write) begin
      if (r_bad) begin
        w_rdata = 32'h0000_0000;
      end else if (r_in_reg) begin
        case (w_reg_idx)
          2'd0:    w_rdata = r_ctrl;
          2'd1:    w_rdata = i_sta;
          2'd2:    w_rdata = r_irq;
          2'd3:    w_rdata = r_mask;
          default: w_rdata = IDLE_DATA;
        endcase
      end else begin
        w_rdata = r_mem[w_ram_idx];
      end
    end else begin
      w_rdata = IDLE_DATA;
    end
  end

  assign bus.hreadyout = r_hreadyout;
  assign bus.hresp     = r_hresp;
  assign bus.hrdata    = w_rdata;
  assign o_ctrl        = r_ctrl;
  assign o_irq         = |(r_irq & r_mask);

endmodule
